// File: rtl/fpu_issue_arbiter.sv
// Round-robin two-client issue arbiter for the shared fixed-point FPU, with a flush cycle between ops.
// Optional macro FPU_ARB_TIMEOUT_EN aborts a BUSY op after TIMEOUT_CYCLES and raises sticky timeout_err.
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`endif
`ifndef FPU_SUB
`define FPU_SUB  2'b01
`endif
`ifndef FPU_MUL
`define FPU_MUL  2'b10
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'b11
`endif

module fpu_issue_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_accept,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_accept,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Counter saturates at the limit so an indefinite wait cannot wrap it.
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             win_q, win_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             timeout_err_q, timeout_err_d;

  logic             idle_s;
  logic             grant0_s;
  logic             grant1_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             timeout_hit_s;
  logic             finish_s;
  logic [WIDTH-1:0] finish_res_s;

  assign idle_s    = (state_q == ST_IDLE);
  assign grant0_s  = idle_s && req0_valid && (!req1_valid || !rr_ptr_q);
  assign grant1_s  = idle_s && req1_valid && (!req0_valid ||  rr_ptr_q);
  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef FPU_ARB_TIMEOUT_EN
  assign timeout_hit_s = (cnt_inc_s == CNT_LIM);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and datapath selection for the IDLE/BUSY/FLUSH sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    finish_s      = 1'b0;
    finish_res_s  = fpu_result;

    case (state_q)
      ST_IDLE: begin
        if (grant1_s) begin
          win_d   = 1'b1;
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_BUSY;
        end else if (grant0_s) begin
          win_d   = 1'b0;
          op_d    = req0_op;
          a_d     = req0_a;
          b_d     = req0_b;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = (cnt_q == CNT_LIM) ? cnt_q : cnt_inc_s;
        if (fpu_ready) begin
          finish_s     = 1'b1;
          finish_res_s = fpu_result;
        end else if (timeout_hit_s) begin
          finish_s      = 1'b1;
          finish_res_s  = {WIDTH{1'b1}};
          timeout_err_d = 1'b1;
        end else begin
          finish_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The op/operand registers double as the FPU drive; zeroing them makes FLUSH/IDLE drive ADD 0/0.
    if (finish_s) begin
      if (win_q) begin
        rsp1_result_d = finish_res_s;
        rsp1_valid_d  = 1'b1;
      end else begin
        rsp0_result_d = finish_res_s;
        rsp0_valid_d  = 1'b1;
      end
      rr_ptr_d = ~win_q;
      op_d     = `FPU_ADD;
      a_d      = {WIDTH{1'b0}};
      b_d      = {WIDTH{1'b0}};
      state_d  = ST_FLUSH;
    end else begin
      rr_ptr_d = rr_ptr_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= 1'b0;
      win_q         <= 1'b0;
      op_q          <= `FPU_ADD;
      a_q           <= {WIDTH{1'b0}};
      b_q           <= {WIDTH{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      rsp0_result_q <= {WIDTH{1'b0}};
      rsp1_result_q <= {WIDTH{1'b0}};
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_q         <= win_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req0_accept   = grant0_s;
  assign req1_accept   = grant1_s;
  assign rsp0_valid    = rsp0_valid_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp0_result   = rsp0_result_q;
  assign rsp1_result   = rsp1_result_q;
  assign fpu_operation = op_q;
  assign fpu_operand_1 = a_q;
  assign fpu_operand_2 = b_q;
  assign busy          = !idle_s;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed self-checking bench for fpu_issue_arbiter with a behavioural fixed-point FPU (FBITS=10).
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`endif
`ifndef FPU_SUB
`define FPU_SUB  2'b01
`endif
`ifndef FPU_MUL
`define FPU_MUL  2'b10
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'b11
`endif

module tb_fpu_issue_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_accept, req1_accept, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic [W-1:0] fpu_operand_1, fpu_operand_2, fpu_result;
  logic [1:0]   fpu_operation;
  logic         fpu_ready, busy, timeout_err;

  int tests = 0;
  int fails = 0;
  logic hold_low = 1'b0;
  logic [3:0] m_cnt;

  always #5 clk = ~clk;

  fpu_issue_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_accept(req0_accept), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_accept(req1_accept), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready), .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      t = r | (32'd1 << i);
      if (({32'd0, t} * {32'd0, t}) <= v) r = t;
    end
    return r;
  endfunction

  // FPU model: ADD/SUB ready at once, MUL after 3 cycles, SQRT after 4; any ADD/SUB cycle restarts it.
  always @(posedge clk) begin
    if (fpu_operation == `FPU_ADD || fpu_operation == `FPU_SUB) m_cnt <= 4'd0;
    else m_cnt <= m_cnt + 4'd1;
  end

  always_comb begin
    logic [63:0] p;
    p = {32'd0, fpu_operand_1} * {32'd0, fpu_operand_2};
    case (fpu_operation)
      `FPU_ADD: fpu_result = fpu_operand_1 + fpu_operand_2;
      `FPU_SUB: fpu_result = fpu_operand_1 - fpu_operand_2;
      `FPU_MUL: fpu_result = p[41:10];
      default:  fpu_result = isqrt({22'd0, fpu_operand_1, 10'd0});
    endcase
    case (fpu_operation)
      `FPU_MUL:  fpu_ready = !hold_low && (m_cnt >= 4'd2);
      `FPU_SQRT: fpu_ready = !hold_low && (m_cnt >= 4'd3);
      default:   fpu_ready = !hold_low;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Issues one op from an IDLE cycle; returns accept-to-rsp latency, leaves the bench one cycle after the rsp.
  task automatic do_op(input int rq, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    logic found;
    if (rq == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    @(negedge clk);
    check("accept", (rq == 0) ? req0_accept : req1_accept, 1'b1);
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      check("other_rsp", (rq == 0) ? rsp1_valid : rsp0_valid, 1'b0);
      if ((rq == 0) ? rsp0_valid : rsp1_valid) begin
        found = 1'b1;
        check("flush_op", fpu_operation, `FPU_ADD);
        check("flush_opnd", fpu_operand_1, 32'd0);
      end else begin
        check("busy_op", fpu_operation, op);
        next_cycle();
        lat++;
      end
    end
    if (!found) check("rsp_wait_expired", 1'b0, 1'b1);
    next_cycle();
  endtask

  initial begin
    int lat;
    int ng;
    int nr;
    int g[$];
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = `FPU_ADD; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = `FPU_ADD; req1_a = 32'd0; req1_b = 32'd0;
    do_reset();

    @(negedge clk);
    check("rst_op", fpu_operation, `FPU_ADD);
    check("rst_opnd1", fpu_operand_1, 32'd0);
    check("rst_opnd2", fpu_operand_2, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_acc", {req0_accept, req1_accept, rsp0_valid, rsp1_valid}, 4'b0000);
    check("rst_tmo", timeout_err, 1'b0);
    next_cycle();

    do_op(0, `FPU_ADD, 32'h600, 32'h800, lat);
    check("add_lat", lat, 2);
    check("add_res", rsp0_result, 32'hE00);
    @(negedge clk);
    check("add_idle", busy, 1'b0);
    check("add_hold", rsp0_result, 32'hE00);
    next_cycle();

    do_op(1, `FPU_MUL, 32'h600, 32'h800, lat);
    check("mul_lat", lat, 4);
    check("mul_res", rsp1_result, 32'hC00);
    check("mul_r0_hold", rsp0_result, 32'hE00);

    do_op(0, `FPU_SQRT, 32'h1000, 32'h0, lat);
    check("sqrt_lat", lat, 5);
    check("sqrt_res", rsp0_result, 32'h800);
    @(negedge clk);
    check("sqrt_idle", busy, 1'b0);
    next_cycle();
    do_op(0, `FPU_SQRT, 32'h2400, 32'h0, lat);
    check("sqrt2_res", rsp0_result, 32'hC00);

    do_reset();
    req0_valid = 1'b1; req0_op = `FPU_ADD; req0_a = 32'h400; req0_b = 32'h400;
    req1_valid = 1'b1; req1_op = `FPU_ADD; req1_a = 32'h800; req1_b = 32'h800;
    nr = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req0_accept) g.push_back(0);
      if (req1_accept) g.push_back(1);
      check("both_acc", req0_accept && req1_accept, 1'b0);
      check("both_rsp", rsp0_valid && rsp1_valid, 1'b0);
      if (rsp0_valid) begin nr++; check("cont_r0", rsp0_result, 32'h800); end
      if (rsp1_valid) begin nr++; check("cont_r1", rsp1_result, 32'h1000); end
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ng = g.size();
    check("grant_count", ng, 6);
    check("rsp_count", nr, 5);
    for (int i = 0; i < ng; i++) check("grant_order", g[i], i % 2);
    repeat (4) next_cycle();

    do_reset();
    do_op(0, `FPU_ADD, 32'h400, 32'h400, lat);
    req1_valid = 1'b1; req1_op = `FPU_MUL; req1_a = 32'h600; req1_b = 32'h800;
    @(negedge clk);
    check("rm_acc1", req1_accept, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    check("rm_busy", busy, 1'b1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = `FPU_ADD; req0_a = 32'h400; req0_b = 32'h400;
    req1_valid = 1'b1; req1_op = `FPU_ADD; req1_a = 32'h800; req1_b = 32'h800;
    @(negedge clk);
    check("rm_idle", busy, 1'b0);
    check("rm_norsp", rsp1_valid, 1'b0);
    check("rm_op", fpu_operation, `FPU_ADD);
    check("rm_rr", {req0_accept, req1_accept}, 2'b10);
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("rm_norsp1", rsp1_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rm_rsp0", rsp0_valid, 1'b1);
    check("rm_res0", rsp0_result, 32'h800);
    check("rm_norsp1b", rsp1_valid, 1'b0);
    next_cycle();

    do_reset();
    hold_low = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
    do_op(0, `FPU_MUL, 32'h600, 32'h800, lat);
    check("tmo_lat", lat, 9);
    check("tmo_res", rsp0_result, 32'hFFFFFFFF);
    check("tmo_err", timeout_err, 1'b1);
    hold_low = 1'b0;
    do_op(1, `FPU_ADD, 32'h600, 32'h800, lat);
    check("tmo_next_res", rsp1_result, 32'hE00);
    check("tmo_sticky", timeout_err, 1'b1);
    do_reset();
    @(negedge clk);
    check("tmo_clear", timeout_err, 1'b0);
    next_cycle();
`else
    req0_valid = 1'b1; req0_op = `FPU_MUL; req0_a = 32'h600; req0_b = 32'h800;
    @(negedge clk);
    check("wait_acc", req0_accept, 1'b1);
    next_cycle();
    req0_valid = 1'b0;
    nr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp0_valid || !busy) nr++;
      next_cycle();
    end
    check("wait_forever", nr, 0);
    check("no_tmo", timeout_err, 1'b0);
    hold_low = 1'b0;
    do_reset();
    @(negedge clk);
    check("wait_rst", busy, 1'b0);
    next_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
